// File: rtl/random_lfsr_n.sv
// random_lfsr_n: Fibonacci LFSR random number generator with optional range limiting.
// Range limiting (mask, rejection, fallback subtraction) is enabled by RANDOM_RANGE_LIMIT_EN.
module random_lfsr_n #(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             carrega,
   input  logic [WIDTH-1:0] semente,
   input  logic             gera,
   input  logic [WIDTH-1:0] limite,
   output logic [WIDTH-1:0] saida,
   output logic             pronto,
   output logic             ocupado
);
   typedef enum logic {OCIOSO, GERANDO} state_t;
   localparam logic [WIDTH-1:0] TAPS = WIDTH == 8  ? WIDTH'(8'hB8) :
                                       WIDTH == 16 ? WIDTH'(16'hD008) : WIDTH'(32'h8020_0003);
   state_t state;
   logic [WIDTH-1:0] lfsr, nxt, sel;
   logic accept;
   assign nxt = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
   assign ocupado = state == GERANDO;
`ifdef RANDOM_RANGE_LIMIT_EN
   logic [WIDTH-1:0] lim, mask, mask_in, masked;
   logic [4:0] rej;
   logic in_range;
   always_comb begin
      mask_in = limite;
      for (int i = 1; i < WIDTH; i = i * 2) mask_in = mask_in | (mask_in >> i);
      masked = nxt & mask;
      in_range = masked <= lim;
      accept = in_range || rej == 5'd16;
      sel = in_range ? masked : masked - (lim + WIDTH'(1));
   end
   always_ff @(posedge clock)
      if (reset || carrega) begin
         rej <= '0;
         lim <= '0;
         mask <= '0;
      end else if (state == OCIOSO && gera) begin
         rej <= '0;
         lim <= limite;
         mask <= mask_in;
      end else if (state == GERANDO) rej <= rej + 5'd1;
`else
   logic unused_limite;
   assign unused_limite = ^limite;
   always_comb begin
      accept = 1'b1;
      sel = nxt;
   end
`endif
   always_ff @(posedge clock)
      if (reset) begin
         lfsr <= WIDTH'(1);
         saida <= '0;
         pronto <= 1'b0;
         state <= OCIOSO;
      end else if (carrega) begin
         lfsr <= semente == '0 ? '1 : semente;
         pronto <= 1'b0;
         state <= OCIOSO;
      end else begin
         pronto <= 1'b0;
         if (state == OCIOSO) begin
            if (gera) state <= GERANDO;
         end else begin
            lfsr <= nxt;
            if (accept) begin
               saida <= sel;
               pronto <= 1'b1;
               state <= OCIOSO;
            end
         end
      end
endmodule

// File: tb/tb_random_lfsr_n.sv
// tb_random_lfsr_n: directed checks of random_lfsr_n (WIDTH=16), both RANDOM_RANGE_LIMIT_EN builds.
module tb_random_lfsr_n;
   logic clock = 1'b0, reset = 1'b0, carrega = 1'b0, gera = 1'b0, pronto, ocupado;
   logic [15:0] semente = '0, limite = '0, saida;
   int n_chk = 0, n_fail = 0, k;

   random_lfsr_n #(.WIDTH(16)) dut (
      .clock(clock), .reset(reset), .carrega(carrega), .semente(semente), .gera(gera),
      .limite(limite), .saida(saida), .pronto(pronto), .ocupado(ocupado)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic request(input logic [15:0] lim);
      limite = lim;
      gera = 1'b1;
      tick();
      chk("busy_after_gera", 32'(ocupado), 1);
      chk("no_pronto_at_capture", 32'(pronto), 0);
      gera = 1'b0;
      tick();
   endtask

   initial begin
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("reset_saida", 32'(saida), 0);
      chk("reset_pronto", 32'(pronto), 0);
      chk("reset_ocupado", 32'(ocupado), 0);
      request(16'hFFFF);
      chk("first_pronto", 32'(pronto), 1);
      chk("first_saida", 32'(saida), 32'h0002);
      chk("first_idle", 32'(ocupado), 0);
      tick();
      chk("pronto_one_cycle", 32'(pronto), 0);
      chk("saida_hold", 32'(saida), 32'h0002);
      // seed 0x000A steps to 0x0015; with the limit enabled, limite=3 masks it to 0x0001
      semente = 16'h000A;
      carrega = 1'b1;
      tick();
      carrega = 1'b0;
      request(16'h0003);
      chk("seed_a_pronto", 32'(pronto), 1);
`ifdef RANDOM_RANGE_LIMIT_EN
      chk("seed_a_saida", 32'(saida), 32'h0001);
`else
      chk("seed_a_saida", 32'(saida), 32'h0015);
`endif
      request(16'hFFFF);
      chk("step_2a", 32'(saida), 32'h002A);
      gera = 1'b1;
      tick();
      tick();
      chk("gera_held_pronto", 32'(pronto), 1);
      chk("gera_held_saida", 32'(saida), 32'h0055);
      gera = 1'b0;
      tick();
      chk("gera_not_queued", 32'(ocupado), 0);
      chk("gera_not_queued_pronto", 32'(pronto), 0);
      chk("saida_stable", 32'(saida), 32'h0055);
      gera = 1'b1;
      tick();
      chk("abort_busy", 32'(ocupado), 1);
      gera = 1'b0;
      carrega = 1'b1;
      semente = 16'h0000;
      tick();
      carrega = 1'b0;
      chk("abort_no_pronto", 32'(pronto), 0);
      chk("abort_idle", 32'(ocupado), 0);
      chk("abort_saida_kept", 32'(saida), 32'h0055);
      request(16'hFFFF);
      chk("zero_seed_saida", 32'(saida), 32'hFFFE);
      request(16'h0000);
      chk("lim0_pronto", 32'(pronto), 1);
`ifdef RANDOM_RANGE_LIMIT_EN
      chk("lim0_saida", 32'(saida), 0);
      for (int r = 0; r < 1000; r++) begin
         limite = 16'd5;
         gera = 1'b1;
         tick();
         gera = 1'b0;
         k = 0;
         do begin
            tick();
            k++;
         end while (!pronto && k < 20);
         chk("lim5_latency_ok", 32'(k <= 17 && pronto), 1);
         chk("lim5_range_ok", 32'(saida <= 16'd5), 1);
      end
`else
      chk("lim0_saida", 32'(saida), 32'hFFFC);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
